// File: rtl/axi_xbar_rsp_pkg.sv
// Shared types and width constants for the crossbar slave-side write responder.
// Response priority lives here so other responders in the slice encode it the same way.
package axi_xbar_rsp_pkg;

   localparam int XBAR_SLV_ID_WIDTH = 6;
   localparam int XBAR_NUM_MASTERS  = 3;
   localparam int XBAR_MST_ID_WIDTH = XBAR_SLV_ID_WIDTH + $clog2(XBAR_NUM_MASTERS);
   localparam int AXI_ADDR_WIDTH    = 32;
   localparam int AXI_DATA_WIDTH    = 64;
   localparam int AXI_STRB_WIDTH    = AXI_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } resp_e;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2
   } burst_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      DELAY = 2'd2,
      RESP  = 2'd3
   } wr_state_e;

   // A decode error outranks a slave error when both were seen during a burst.
   function automatic resp_e encodeResp(input logic slvErr, input logic decErr);
      if (decErr) return DECERR;
      if (slvErr) return SLVERR;
      return OKAY;
   endfunction

endpackage

// File: rtl/axi_xbar_rsp_mem.sv
// Byte-enabled word memory with a synchronous write port and a registered debug read port.
// A same-cycle read and write of one word returns the pre-write contents.
module axi_xbar_rsp_mem
   import axi_xbar_rsp_pkg::*;
#(
   parameter int DATA_WIDTH = AXI_DATA_WIDTH,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_wrEn,
   input  logic [$clog2(MEM_DEPTH)-1:0] i_wrIdx,
   input  logic [DATA_WIDTH-1:0]        i_wrData,
   input  logic [DATA_WIDTH/8-1:0]      i_wrStrb,
   input  logic [$clog2(MEM_DEPTH)-1:0] i_rdIdx,
   output logic [DATA_WIDTH-1:0]        o_rdData
);

   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] r_rdData;

   // Storage is never reset so written data survives a mid-burst reset.
   always_ff @(posedge i_clk) begin
      if (i_wrEn) begin
         for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (i_wrStrb[b]) begin
               r_mem[i_wrIdx][8*b +: 8] <= i_wrData[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdData <= '0;
      end else begin
         r_rdData <= r_mem[i_rdIdx];
      end
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/axi_xbar_slv_wr_responder.sv
// AXI4 write responder on one crossbar slave port: one outstanding burst, byte-enabled store, B with echoed ID.
// Define AXI_WR_RSP_DELAY_EN to add the b_delay_i port and a programmable wait before B.
module axi_xbar_slv_wr_responder
   import axi_xbar_rsp_pkg::*;
#(
   parameter int                  ID_WIDTH   = XBAR_MST_ID_WIDTH,
   parameter int                  ADDR_WIDTH = AXI_ADDR_WIDTH,
   parameter int                  DATA_WIDTH = AXI_DATA_WIDTH,
   parameter int                  MEM_DEPTH  = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [ID_WIDTH-1:0]          aw_id_i,
   input  logic [ADDR_WIDTH-1:0]        aw_addr_i,
   input  logic [7:0]                   aw_len_i,
   input  logic [2:0]                   aw_size_i,
   input  logic [1:0]                   aw_burst_i,
   input  logic                         aw_valid_i,
   output logic                         aw_ready_o,
   input  logic [DATA_WIDTH-1:0]        w_data_i,
   input  logic [DATA_WIDTH/8-1:0]      w_strb_i,
   input  logic                         w_last_i,
   input  logic                         w_valid_i,
   output logic                         w_ready_o,
   output logic [ID_WIDTH-1:0]          b_id_o,
   output logic [1:0]                   b_resp_o,
   output logic                         b_valid_o,
   input  logic                         b_ready_i,
`ifdef AXI_WR_RSP_DELAY_EN
   input  logic [7:0]                   b_delay_i,
`endif
   input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr_i,
   output logic [DATA_WIDTH-1:0]        dbg_data_o
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * STRB_W);
   localparam logic [2:0]          FULL_SIZE = 3'(OFF_W);

   // Extra top bit makes addresses below BASE_ADDR wrap to a huge offset and fail the range test.
   function automatic logic [ADDR_WIDTH:0] byteOffset(input logic [ADDR_WIDTH-1:0] addr);
      return {1'b0, addr} - {1'b0, BASE_ADDR};
   endfunction

   wr_state_e             r_state;
   wr_state_e             w_nextState;
   logic [ID_WIDTH-1:0]   r_id;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_len;
   logic [7:0]            r_cnt;
   logic                  r_incr;
   logic                  r_slverr;
   logic                  r_decerr;
   logic                  w_awHs;
   logic                  w_wHs;
   logic                  w_lastBeat;
   logic                  w_beatInRange;
   logic                  w_memWe;
   logic [ADDR_WIDTH:0]   w_awOff;
   logic [ADDR_WIDTH:0]   w_beatOff;
`ifdef AXI_WR_RSP_DELAY_EN
   logic [7:0]            r_delayCnt;
`endif

   assign w_awHs        = aw_valid_i && aw_ready_o;
   assign w_wHs         = w_valid_i && w_ready_o;
   assign w_lastBeat    = (r_cnt == r_len);
   assign w_awOff       = byteOffset(aw_addr_i);
   assign w_beatOff     = byteOffset(r_addr);
   assign w_beatInRange = (w_beatOff < MEM_BYTES);
   assign w_memWe       = w_wHs && w_beatInRange && !r_slverr && !r_decerr && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The beat counter, not w_last_i, decides when the burst is over.
   always_comb begin
      w_nextState = r_state;
      aw_ready_o  = 1'b0;
      w_ready_o   = 1'b0;
      b_valid_o   = 1'b0;
      case (r_state)
         IDLE: begin
            aw_ready_o = 1'b1;
            if (aw_valid_i) w_nextState = DATA;
         end
         DATA: begin
            w_ready_o = 1'b1;
            if (w_valid_i && w_lastBeat) begin
`ifdef AXI_WR_RSP_DELAY_EN
               w_nextState = (b_delay_i == 8'd0) ? RESP : DELAY;
`else
               w_nextState = RESP;
`endif
            end
         end
`ifdef AXI_WR_RSP_DELAY_EN
         DELAY: begin
            if (r_delayCnt == 8'd1) w_nextState = RESP;
         end
`endif
         RESP: begin
            b_valid_o = 1'b1;
            if (b_ready_i) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Error flags are sticky for the whole burst; a bad beat only adds to them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_id     <= '0;
         r_addr   <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_incr   <= 1'b0;
         r_slverr <= 1'b0;
         r_decerr <= 1'b0;
`ifdef AXI_WR_RSP_DELAY_EN
         r_delayCnt <= '0;
`endif
      end else begin
         if (w_awHs) begin
            r_id     <= aw_id_i;
            r_addr   <= aw_addr_i;
            r_len    <= aw_len_i;
            r_cnt    <= '0;
            r_incr   <= (aw_burst_i == INCR);
            r_slverr <= !((aw_burst_i == FIXED) || (aw_burst_i == INCR)) || (aw_size_i != FULL_SIZE);
            r_decerr <= !(w_awOff < MEM_BYTES);
         end
         if (w_wHs) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_incr) r_addr <= r_addr + ADDR_WIDTH'(STRB_W);
            if (!w_beatInRange) r_decerr <= 1'b1;
            if (w_last_i != w_lastBeat) r_slverr <= 1'b1;
`ifdef AXI_WR_RSP_DELAY_EN
            if (w_lastBeat) r_delayCnt <= b_delay_i;
`endif
         end
`ifdef AXI_WR_RSP_DELAY_EN
         if (r_state == DELAY) r_delayCnt <= r_delayCnt - 8'd1;
`endif
      end
   end

   assign b_id_o   = r_id;
   assign b_resp_o = encodeResp(r_slverr, r_decerr);

   axi_xbar_rsp_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_mem (
      .i_clk    (clk_i),
      .i_rst    (rst_i),
      .i_wrEn   (w_memWe),
      .i_wrIdx  (w_beatOff[OFF_W +: IDX_W]),
      .i_wrData (w_data_i),
      .i_wrStrb (w_strb_i),
      .i_rdIdx  (dbg_addr_i),
      .o_rdData (dbg_data_o)
   );

endmodule
